// File: rtl/rgb_window_capture_if.sv
// Frame-buffer write port for the centred-window capture block.
//   wr_en   : one-cycle write strobe per captured pixel
//   wr_addr : buffer address, y_local*WIDTH + x_local
//   wr_data : packed {R8,G8,B8}
// master : the capture block, which drives the port.
// slave  : the frame buffer, which receives it.
interface rgb_window_capture_if #(
  parameter int unsigned AW = 7
) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/rgb_window_capture.sv
// Centred-window frame grabber.
// It watches a 12-bit RGB pixel stream and its X/Y counters. On request it
// captures the centred WIDTH x HEIGHT window of the next frame. Each pixel
// is packed to 24 bits and written into a NPIX-entry frame buffer.
// Ports:
//   iCLK, iRST          pixel clock; asynchronous active-low reset
//   iRed/iGreen/iBlue   12-bit samples
//   iDVAL               pixel valid
//   iX_Cont/iY_Cont     current pixel column / line
//   iStart              capture request, only honoured when idle
//   oBusy               armed or capturing
//   oDone               one-cycle pulse after the last window write
//   oPix_Count          pixels written in the current/last capture
//   wr                  buffer write port (master)
module rgb_window_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned HEIGHT   = 10,
  parameter int unsigned ROUND    = 1,
  localparam int unsigned NPIX    = WIDTH * HEIGHT,
  localparam int unsigned AW      = $clog2(NPIX),
  localparam int unsigned CW      = $clog2(NPIX + 1)
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [11:0]         iRed,
  input  logic [11:0]         iGreen,
  input  logic [11:0]         iBlue,
  input  logic                iDVAL,
  input  logic [10:0]         iX_Cont,
  input  logic [10:0]         iY_Cont,
  input  logic                iStart,
  output logic                oBusy,
  output logic                oDone,
  output logic [CW-1:0]       oPix_Count,
  rgb_window_capture_if.master wr
);

  localparam int unsigned X_START = (H_ACTIVE - WIDTH) / 2;
  localparam int unsigned Y_START = (V_ACTIVE - HEIGHT) / 2;

  localparam logic [10:0] XS = 11'(X_START);
  localparam logic [10:0] XE = 11'(X_START + WIDTH - 1);
  localparam logic [10:0] YS = 11'(Y_START);
  localparam logic [10:0] YE = 11'(Y_START + HEIGHT - 1);

  // StDrain is the cycle in which the LAST write strobe is on the bus.
  // oDone is raised in the following cycle, once StDone is entered.
  typedef enum logic [2:0] {
    StIdle,
    StWaitSof,
    StCapture,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic          in_win, sof, last, pre_win;
  logic [AW-1:0] x_loc, y_loc, wr_addr_c;
  logic [23:0]   wr_data_c;

  logic          wr_fire, cnt_clr, cnt_set1, cnt_inc;

  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [23:0]   wr_data_q;
  logic [CW-1:0] cnt_q;

  // 12->8 conversion. With ROUND set, bit 3 rounds up and the result
  // saturates, so 12'hFF8..12'hFFF map to 8'hFF instead of wrapping.
  function automatic logic [7:0] conv(input logic [11:0] c);
    logic [8:0] s;
    s = {1'b0, c[11:4]} + {8'd0, c[3]};
    if (ROUND == 0) begin
      conv = c[11:4];
    end else begin
      conv = s[8] ? 8'hFF : s[7:0];
    end
  endfunction

  // Window decode, taken straight from the counters.
  always_comb begin
    in_win  = iDVAL && (iX_Cont >= XS) && (iX_Cont <= XE) &&
              (iY_Cont >= YS) && (iY_Cont <= YE);
    sof     = iDVAL && (iX_Cont == XS) && (iY_Cont == YS);
    last    = iDVAL && (iX_Cont == XE) && (iY_Cont == YE);
    pre_win = iDVAL && (iY_Cont < YS);
    // The address is derived from position, not from a running counter.
    // A dropped pixel therefore never shifts later addresses. Truncating
    // before the multiply keeps the low AW bits exact.
    x_loc     = AW'(iX_Cont - XS);
    y_loc     = AW'(iY_Cont - YS);
    wr_addr_c = y_loc * AW'(WIDTH) + x_loc;
    wr_data_c = {conv(iRed), conv(iGreen), conv(iBlue)};
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (iStart) state_d = StWaitSof;
      end
      StWaitSof: begin
        if (sof) state_d = last ? StDrain : StCapture;
      end
      StCapture: begin
        if (in_win) begin
          if (last) state_d = StDrain;
        end else if (pre_win) begin
          // The frame restarted before the window completed.
          state_d = StWaitSof;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath control
  always_comb begin
    wr_fire  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_set1 = 1'b0;
    cnt_inc  = 1'b0;
    oBusy    = 1'b0;
    oDone    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_clr = iStart;
      end
      StWaitSof: begin
        oBusy = 1'b1;
        if (sof) begin
          wr_fire  = 1'b1;
          cnt_set1 = 1'b1;
        end
      end
      StCapture: begin
        oBusy = 1'b1;
        if (in_win) begin
          wr_fire = 1'b1;
          // A SOF seen mid-capture restarts the count at this pixel.
          if (sof) cnt_set1 = 1'b1;
          else     cnt_inc  = 1'b1;
        end else if (pre_win) begin
          cnt_clr = 1'b1;
        end
      end
      StDrain: begin
        oBusy = 1'b1;
      end
      StDone: begin
        oDone = 1'b1;
      end
      default: ;
    endcase
  end

  // Write port and pixel counter. Address and data hold between strobes.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wr_en_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= wr_addr_c;
        wr_data_q <= wr_data_c;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_set1) begin
        cnt_q <= CW'(1);
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign wr.wr_en    = wr_en_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign oPix_Count  = cnt_q;

endmodule

// File: doc/rgb_window_capture.md
Name: rgb_window_capture

Overview:
- Write-side counterpart of the centred-window overlay reader.
- Watches the 12-bit RGB pixel stream with its X/Y counters.
- On request, crops the centred WIDTH x HEIGHT window of one frame.
- Packs each pixel to 24-bit {R8,G8,B8}.
- Drives a simple synchronous write port into the NPIX-entry frame buffer that the overlay reader later displays.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- WIDTH, 10: window width in pixels.
- HEIGHT, 10: window height in lines.
- ROUND, 1: 1 = round-to-nearest 12->8 with saturation; 0 = plain truncation.
- Derived, not overridable: X_START=(H_ACTIVE-WIDTH)/2 (315), Y_START=(V_ACTIVE-HEIGHT)/2 (235), NPIX=WIDTH*HEIGHT (100), AW=clog2(NPIX) (7), CW=clog2(NPIX+1) (7).

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iRed  in  12  red sample.
- iGreen  in  12  green sample.
- iBlue  in  12  blue sample.
- iDVAL  in  1  pixel valid.
- iX_Cont  in  11  current pixel column.
- iY_Cont  in  11  current pixel line.
- iStart  in  1  capture request; level sampled, only honoured in IDLE.
- oBusy  out  1  high in WAIT_SOF and CAPTURE.
- oDone  out  1  one-cycle pulse when a window capture completes.
- oPix_Count  out  CW  number of pixels written in the current/last capture.
- oWR_EN  out  1  buffer write strobe.
- oWR_ADDR  out  AW  buffer address, y_local*WIDTH + x_local.
- oWR_DATA  out  24  {R8,G8,B8}.

Behaviour:
- Reset (async, iRST=0): state IDLE; oBusy, oDone, oWR_EN = 0; oWR_ADDR, oWR_DATA, oPix_Count = 0.
- in_win = iDVAL && X_START<=iX_Cont<X_START+WIDTH && Y_START<=iY_Cont<Y_START+HEIGHT.
- x_local = iX_Cont-X_START and y_local = iY_Cont-Y_START, computed from the counters. The write address never comes from an internal counter, so a dropped pixel does not shift later addresses.
- SOF = iDVAL && iX_Cont==X_START && iY_Cont==Y_START.
- LAST = iDVAL && iX_Cont==X_START+WIDTH-1 && iY_Cont==Y_START+HEIGHT-1.
- Channel conversion (each channel):
  - ROUND=0: c8 = c12[11:4].
  - ROUND=1: c8 = c12[11:4] + c12[3], saturating at 8'hFF (12'hFF8..12'hFFF -> FF).
- State machine:
  - IDLE: iStart=1 -> WAIT_SOF; oPix_Count cleared to 0 on that edge.
  - WAIT_SOF: no writes. SOF -> CAPTURE, and that SOF pixel is written (addr 0).
  - CAPTURE: every in_win pixel is written; oPix_Count += 1 per write. LAST -> DONE (LAST pixel written).
  - CAPTURE, frame restart: iDVAL && iY_Cont<Y_START -> WAIT_SOF. oPix_Count clears; buffer contents are left as-is and overwritten next frame.
  - DONE: one cycle, oDone=1 -> IDLE. oPix_Count holds until the next accepted iStart.
- Write latency: exactly 1 cycle. Pixel presented at edge N gives oWR_EN/oWR_ADDR/oWR_DATA valid on cycle N+1. oWR_EN is high for one cycle per pixel and low otherwise; addr/data hold their last values while oWR_EN=0.
- oDone is asserted in the cycle after the LAST write strobe.
- iStart while oBusy=1 or in DONE is ignored, with no re-arm queued.
- SOF arriving while in CAPTURE (mid-window restart) is treated as a restart: the cycle writes addr 0 and oPix_Count becomes 1.
- Missed pixels (iDVAL=0 inside the window) are simply not written. If LAST is missed, capture continues into the next frame until LAST is seen or a restart occurs.
- Capture from SOF mid-frame is impossible by construction: arming between frames or mid-frame always waits for the next SOF.

Test Plan:
- Reset: assert iRST=0 mid-stream -> all outputs 0 asynchronously, state IDLE. Afterwards a full frame with no iStart -> zero writes.
- Full frame, constant R=12'hAB7, G=12'hAB8, B=12'hFFC, ROUND=1 -> 100 writes, data 24'hABACFF. With ROUND=0 -> 24'hABABFF.
- Address walk, data = {x_local,y_local} pattern:
  - first write addr 0 the cycle after (315,235);
  - addr 10 after (315,236);
  - last addr 99 after (324,244);
  - oDone one cycle after that write; oPix_Count=100; oBusy falls with DONE.
- Arm mid-frame (iStart at Y=240) -> no writes in the current frame; capture of the full window in the next frame.
- iDVAL low at (317,238) and (320,241) -> those addresses (32, 65) are not written; oPix_Count=98; oDone still pulses.
- iStart re-pulsed during CAPTURE and during the DONE cycle -> ignored, no second capture. Frame restart (Y back to 0 at Y=238) -> return to WAIT_SOF, count 0, full recapture next frame.
